// File: rtl/imem_arbiter_pkg.sv
// Shared constants and encodings for the instruction-memory arbiter and its response buffer.
package imem_arbiter_pkg;

  localparam int unsigned ImemAddrW   = 10;
  localparam int unsigned ImemMaxWait = 4;

  typedef enum logic [1:0] {
    TagNone     = 2'd0,
    TagFetch    = 2'd1,
    TagFetchErr = 2'd2,
    TagLoadRd   = 2'd3
  } tag_e;

  typedef enum logic [0:0] {
    StPass = 1'b0,
    StHold = 1'b1
  } rsp_state_e;

  function automatic logic is_fetch_tag(tag_e tag);
    return (tag == TagFetch) || (tag == TagFetchErr);
  endfunction

endpackage

// File: rtl/imem_resp_buf.sv
// Fetch response register: passes BRAM data through, or holds it while the fetch stage stalls.
module imem_resp_buf
  import imem_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        rsp_valid_i,
  input  logic        rsp_err_i,
  input  logic [31:0] rsp_data_i,
  input  logic        rready_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        err_o
);

  rsp_state_e  state_q, state_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        hold_err_q, hold_err_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StPass;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    unique case (state_q)
      StPass: begin
        if (valid_o && !rready_i) begin
          state_d     = StHold;
          hold_data_d = data_o;
          hold_err_d  = err_o;
        end
      end
      StHold: begin
        if (flush_i || rready_i) state_d = StPass;
      end
      default: state_d = StPass;
    endcase
  end

  always_comb begin
    valid_o = 1'b0;
    data_o  = '0;
    err_o   = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        StPass: begin
          valid_o = rsp_valid_i && !flush_i;
          err_o   = valid_o && rsp_err_i;
          data_o  = (valid_o && !rsp_err_i) ? rsp_data_i : '0;
        end
        StHold: begin
          valid_o = !flush_i;
          err_o   = valid_o && hold_err_q;
          data_o  = valid_o ? hold_data_q : '0;
        end
        default: valid_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Per-cycle arbiter sharing the instruction BRAM between fetch and the loader, with a bounded
// fetch wait and tagged one-cycle read responses.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ImemAddrW,
  parameter int unsigned MAX_WAIT = ImemMaxWait
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              f_req_i,
  input  logic [31:0]       f_addr_i,
  output logic              f_ready_o,
  input  logic              f_flush_i,
  output logic              f_rvalid_o,
  output logic [31:0]       f_rdata_o,
  output logic              f_rerr_o,
  input  logic              f_rready_i,
  input  logic              l_req_i,
  input  logic              l_we_i,
  input  logic [31:0]       l_addr_i,
  input  logic [31:0]       l_wdata_i,
  output logic              l_ready_o,
  output logic              l_rvalid_o,
  output logic [31:0]       l_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  input  logic [31:0]       mem_dout_i
);

  localparam logic [2:0] MaxWaitCnt = 3'(MAX_WAIT);

  logic [2:0] wait_q, wait_d;
  tag_e       tag_q, tag_d;
  logic       f_elig, f_win, l_win, f_mis;

  // Address bits outside the word index carry no meaning for the BRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr_i[31:ADDR_W+2], l_addr_i[31:ADDR_W+2], l_addr_i[1:0]};

  always_comb begin
    f_mis  = f_addr_i[1:0] != 2'b00;
    f_elig = !reset_i && f_req_i && (!f_rvalid_o || f_rready_i);
    f_win  = f_elig && (!l_req_i || (wait_q == MaxWaitCnt));
    l_win  = !reset_i && l_req_i && !f_win;
  end

  always_comb begin
    f_ready_o  = f_win;
    l_ready_o  = l_win;
    mem_en_o   = l_win || (f_win && !f_mis);
    mem_we_o   = l_win && l_we_i;
    mem_din_o  = l_wdata_i;
    mem_addr_o = '0;
    if (l_win)      mem_addr_o = l_addr_i[ADDR_W+1:2];
    else if (f_win) mem_addr_o = f_addr_i[ADDR_W+1:2];
  end

  always_comb begin
    wait_d = wait_q;
    if (f_win)       wait_d = '0;
    else if (f_elig) wait_d = wait_q + 3'd1;
    tag_d = TagNone;
    if (f_win)                tag_d = f_mis ? TagFetchErr : TagFetch;
    else if (l_win && !l_we_i) tag_d = TagLoadRd;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_q <= '0;
      tag_q  <= TagNone;
    end else begin
      wait_q <= wait_d;
      tag_q  <= tag_d;
    end
  end

  always_comb begin
    l_rvalid_o = !reset_i && (tag_q == TagLoadRd);
    l_rdata_o  = l_rvalid_o ? mem_dout_i : '0;
  end

  imem_resp_buf u_resp_buf (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (f_flush_i),
    .rsp_valid_i (is_fetch_tag(tag_q)),
    .rsp_err_i   (tag_q == TagFetchErr),
    .rsp_data_i  (mem_dout_i),
    .rready_i    (f_rready_i),
    .valid_o     (f_rvalid_o),
    .data_o      (f_rdata_o),
    .err_o       (f_rerr_o)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a BRAM model and response scoreboards.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_flush, f_rready, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_ready, f_rvalid, f_rerr, l_ready, l_rvalid, mem_en, mem_we;
  logic [31:0] f_rdata, l_rdata, mem_din, mem_dout;
  logic [9:0]  mem_addr;

  logic [31:0] bram [1024];
  logic [31:0] ref_mem [1024];
  logic [32:0] fq [$];
  logic [31:0] lq [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_din;
      else        mem_dout <= bram[mem_addr];
    end
  end

  imem_arbiter dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .f_req_i    (f_req),
    .f_addr_i   (f_addr),
    .f_ready_o  (f_ready),
    .f_flush_i  (f_flush),
    .f_rvalid_o (f_rvalid),
    .f_rdata_o  (f_rdata),
    .f_rerr_o   (f_rerr),
    .f_rready_i (f_rready),
    .l_req_i    (l_req),
    .l_we_i     (l_we),
    .l_addr_i   (l_addr),
    .l_wdata_i  (l_wdata),
    .l_ready_o  (l_ready),
    .l_rvalid_o (l_rvalid),
    .l_rdata_o  (l_rdata),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_din_o  (mem_din),
    .mem_dout_i (mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check responses from earlier grants, then this cycle's grant.
  task automatic step(input logic fr, input logic [31:0] fa, input logic fl, input logic rr,
                      input logic lr, input logic lw, input logic [31:0] la,
                      input logic [31:0] ld, input logic exp_f, input logic exp_l);
    logic [32:0] e;
    @(negedge clk);
    reset = 1'b0; f_req = fr; f_addr = fa; f_flush = fl; f_rready = rr;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
    #1;
    if (fl) fq.delete();
    if (fq.size() == 0) chk("f_rvalid_idle", 32'(f_rvalid), 32'd0);
    else begin
      e = fq[0];
      chk("f_rvalid", 32'(f_rvalid), 32'd1);
      chk("f_rdata", f_rdata, e[31:0]);
      chk("f_rerr", 32'(f_rerr), 32'(e[32]));
      if (rr) void'(fq.pop_front());
    end
    if (lq.size() == 0) chk("l_rvalid_idle", 32'(l_rvalid), 32'd0);
    else begin
      chk("l_rvalid", 32'(l_rvalid), 32'd1);
      chk("l_rdata", l_rdata, lq.pop_front());
    end
    chk("f_ready", 32'(f_ready), 32'(exp_f));
    chk("l_ready", 32'(l_ready), 32'(exp_l));
    if (exp_f) begin
      chk("mem_we_f", 32'(mem_we), 32'd0);
      if (fa[1:0] != 2'b00) begin
        chk("mem_en_mis", 32'(mem_en), 32'd0);
        fq.push_back({1'b1, 32'd0});
      end else begin
        chk("mem_en_f", 32'(mem_en), 32'd1);
        chk("mem_addr_f", 32'(mem_addr), 32'(fa[11:2]));
        fq.push_back({1'b0, ref_mem[fa[11:2]]});
      end
    end else if (exp_l) begin
      chk("mem_en_l", 32'(mem_en), 32'd1);
      chk("mem_we_l", 32'(mem_we), 32'(lw));
      chk("mem_addr_l", 32'(mem_addr), 32'(la[11:2]));
      if (lw) ref_mem[la[11:2]] = ld;
      else    lq.push_back(ref_mem[la[11:2]]);
    end else begin
      chk("mem_en_idle", 32'(mem_en), 32'd0);
      chk("mem_we_idle", 32'(mem_we), 32'd0);
    end
  endtask

  task automatic reset_step(input logic busy);
    @(negedge clk);
    reset = 1'b1; f_req = busy; f_addr = 32'h8; f_flush = 1'b0; f_rready = 1'b1;
    l_req = busy; l_we = 1'b0; l_addr = 32'h44; l_wdata = 32'd0;
    #1;
    fq.delete();
    lq.delete();
    chk("rst_f_ready", 32'(f_ready), 32'd0);
    chk("rst_l_ready", 32'(l_ready), 32'd0);
    chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_f_rdata", f_rdata, 32'd0);
    chk("rst_f_rerr", 32'(f_rerr), 32'd0);
    chk("rst_l_rvalid", 32'(l_rvalid), 32'd0);
    chk("rst_l_rdata", l_rdata, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic lwrite(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, a, d, 1'b0, 1'b1);
  endtask

  initial begin
    reset_step(1'b0);
    reset_step(1'b1);
    idle();
    // Load contents through the loader port.
    lwrite(32'h0, 32'h11);
    lwrite(32'h4, 32'h22);
    lwrite(32'h8, 32'h33);
    lwrite(32'h100, 32'hCAFE0100);
    // Streaming fetch.
    step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();
    // Starvation bound: loader wins 4, fetch wins the 5th.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, (k % 5) == 4, (k % 5) != 4);
    end
    // Write then read the same word.
    lwrite(32'h40, 32'hDEADBEEF);
    step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h41, 32'h0, 1'b0, 1'b1);
    idle();
    // Stall for 3 cycles on 0x22, then flush while held; fetch re-granted that cycle.
    step(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();
    // Flush in the same cycle as a fetch grant kills only the older response.
    step(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();
    // Misaligned fetch.
    step(1'b1, 32'h6, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();
    // Reset mid-flight drops the pending response.
    step(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    reset_step(1'b1);
    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
